err_code_display: RTL and testbench
===================================

// Module: err_code_display
// PURPOSE
//  Error-code logger and 4-digit 7-segment annunciator for the processor top level.
//  Captures each new non-zero error code into a DEPTH-entry FIFO.
//  Shows the oldest unacknowledged code as "E r. H L":
//    HEX0='E', HEX1='r' with DP lit, HEX2/HEX3 = code high/low hex nibble.
//  Operator acknowledges codes one at a time; display blinks when codes were lost to overflow.
// PARAMETERS
//  CODE_W      8           error-code width; CODE_W<=8 (two hex digits), upper nibble zero-extended
//  DEPTH       4           FIFO entries, power of two, >=2
//  BLINK_DIV   25_000_000  clk cycles per blink half-period (0.5 s at 50 MHz)
//  SEG_ACT_LO  0           0: segment bit 1=lit; 1: all HEX/DP outputs inverted
// PORTS
//  clk         in   1         system clock, all logic on posedge
//  rst_n       in   1         asynchronous active-low reset
//  ER_CDE      in   CODE_W    error code from processor, 0 = no error, level-held
//  ack         in   1         synchronous level; rising edge pops the FIFO head
//  clear       in   1         synchronous; flushes FIFO and overflow flag
//  HEX0..HEX3  out  7 each    segments gfedcba
//  HEX1DP      out  1         decimal point after 'r'
//  err_pending out  1         FIFO non-empty
//  err_count   out  $clog2(DEPTH)+1  entries held, 0..DEPTH
//  overflow    out  1         sticky: a code was dropped while full
// BEHAVIOUR
//  Reset: FIFO empty, count=0, overflow=0, code_q=0, ack_q=0, blink counter=0, phase=on.
//    Reset output state: all HEX=blank, HEX1DP=0, err_pending=0 (polarity per SEG_ACT_LO).
//  Capture: push when ER_CDE!=0 && ER_CDE!=code_q.
//    code_q <= ER_CDE every cycle; a held code is logged once.
//    Code changes A->B log B; A->0->A logs A twice.
//  Ack: pop when ack && !ack_q (ack_q <= ack each cycle). Pop on empty is ignored.
//  Simultaneous push+pop:
//    both take effect and count is unchanged;
//    if full, push is accepted because pop frees the slot; overflow is not set.
//  Full: push without pop while count==DEPTH drops the code and sets overflow.
//  clear: wins over push/pop in the same cycle; empties FIFO, overflow<=0; code_q still updates.
//  Pointers are log2(DEPTH) bits and wrap naturally; count is tracked separately.
//  Display (registered, 1 cycle after FIFO/flag change):
//    empty -> all blank, DP off.
//    non-empty -> E/r./hi/lo of head; hex digits 0-F use standard glyphs (A,b,C,d,E,F).
//    While overflow=1, all four digits and DP blank during the off phase.
//    Blink toggles every BLINK_DIV cycles; the counter free-runs from reset.
//  Latency: ER_CDE new at edge N -> FIFO written at N -> HEX valid after N+1.
//  err_pending/err_count/overflow are registered with the FIFO (valid after edge N).
//  Reset mid-operation: immediate return to reset state; no partial writes survive.
// STRUCTURE
//  Shared package err_disp_pkg:
//    SEG_BLANK=7'h00, SEG_E=7'b1111001, SEG_R=7'b1010000, hex glyph table.
//  Sub-module seg7_hex_enc: combinational 4-bit -> 7-segment, instantiated twice (HEX2, HEX3).
//  Top holds FIFO regs/pointers, edge detects, blink divider, output registers and SEG_ACT_LO inversion.
// TESTING (BLINK_DIV=4 for sim, DEPTH=4)
//  reset, ER_CDE=0 -> HEX0..3=7'h00, HEX1DP=0, err_count=0, overflow=0.
//  ER_CDE=8'h03 held 10 cycles -> count=1 once.
//    HEX0=1111001, HEX1=1010000, DP=1, HEX2=0111111, HEX3=1001111.
//  codes 1,2,3,4,5 each with a 0 gap -> count=4, overflow=1, head=1; HEX blanks/unblanks every 4 cycles.
//  ack rising edges x2 with ack held high between edges -> exactly 2 pops, head=3, count=2.
//  full FIFO, ack edge in same cycle as new code 8'h06 -> count stays 4, overflow unchanged, tail=6.
//  rst_n low mid-blink while count=3 -> outputs blank immediately (async); after release count=0.
//  clear together with push 8'h07 -> count=0, overflow=0.

Source files
------------

// File: rtl/err_disp_pkg.sv
// rtl/err_disp_pkg.sv - shared segment glyphs for the error-code annunciator
package err_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_R     = 7'b1010000;

    // gfedcba glyphs for 0-9, A, b, C, d, E, F
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_enc.sv
// rtl/seg7_hex_enc.sv - combinational hex nibble to 7-segment glyph
module seg7_hex_enc
    import err_disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_GLYPH[nib_i];

endmodule

// File: rtl/err_code_display.sv
// rtl/err_code_display.sv - error-code FIFO logger driving a 4-digit "E r. H L" display
module err_code_display
    import err_disp_pkg::*;
#(
    parameter int CODE_W     = 8,
    parameter int DEPTH      = 4,
    parameter int BLINK_DIV  = 25_000_000,
    parameter bit SEG_ACT_LO = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CODE_W-1:0]          ER_CDE,
    input  logic                       ack,
    input  logic                       clear,
    output logic [6:0]                 HEX0,
    output logic [6:0]                 HEX1,
    output logic [6:0]                 HEX2,
    output logic [6:0]                 HEX3,
    output logic                       HEX1DP,
    output logic                       err_pending,
    output logic [$clog2(DEPTH):0]     err_count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [CODE_W-1:0] code_q;
    logic              ack_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [DIV_W-1:0]  blink_cnt_q;
    logic              phase_q;
    logic [6:0]        hex0_q, hex1_q, hex2_q, hex3_q;
    logic [6:0]        hex0_d, hex1_d, hex2_d, hex3_d;
    logic              dp_q, dp_d;
    logic              push, pop, full, wr_en;
    logic [7:0]        head8;
    logic [6:0]        seg_hi, seg_lo;

    always_comb begin
        push  = (ER_CDE != '0) && (ER_CDE != code_q);
        pop   = ack && !ack_q && (count_q != '0);
        full  = (count_q == CNT_W'(DEPTH));
        // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
        wr_en = push && (!full || pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !wr_en) count_d = count_q - CNT_W'(1);
            if (push && full && !pop) ovf_d = 1'b1;
        end
    end

    always_comb begin
        head8 = '0;
        head8[CODE_W-1:0] = mem_q[rd_ptr_q];
    end

    seg7_hex_enc u_enc_hi (.nib_i(head8[7:4]), .seg_o(seg_hi));
    seg7_hex_enc u_enc_lo (.nib_i(head8[3:0]), .seg_o(seg_lo));

    always_comb begin
        hex0_d = SEG_BLANK;
        hex1_d = SEG_BLANK;
        hex2_d = SEG_BLANK;
        hex3_d = SEG_BLANK;
        dp_d   = 1'b0;
        if ((count_q != '0) && !(ovf_q && !phase_q)) begin
            hex0_d = SEG_E;
            hex1_d = SEG_R;
            hex2_d = seg_hi;
            hex3_d = seg_lo;
            dp_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            code_q      <= '0;
            ack_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            hex0_q      <= SEG_BLANK;
            hex1_q      <= SEG_BLANK;
            hex2_q      <= SEG_BLANK;
            hex3_q      <= SEG_BLANK;
            dp_q        <= 1'b0;
        end else begin
            code_q <= ER_CDE;
            ack_q  <= ack;
            if (wr_en && !clear) mem_q[wr_ptr_q] <= ER_CDE;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (blink_cnt_q == DIV_W'(BLINK_DIV - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= !phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + DIV_W'(1);
            end
            hex0_q <= hex0_d;
            hex1_q <= hex1_d;
            hex2_q <= hex2_d;
            hex3_q <= hex3_d;
            dp_q   <= dp_d;
        end
    end

    assign HEX0        = hex0_q ^ {7{SEG_ACT_LO}};
    assign HEX1        = hex1_q ^ {7{SEG_ACT_LO}};
    assign HEX2        = hex2_q ^ {7{SEG_ACT_LO}};
    assign HEX3        = hex3_q ^ {7{SEG_ACT_LO}};
    assign HEX1DP      = dp_q ^ SEG_ACT_LO;
    assign err_pending = (count_q != '0);
    assign err_count   = count_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_err_code_display.sv
// tb/tb_err_code_display.sv - randomized bench for err_code_display against a queue model
module tb_err_code_display;

    localparam int DEPTH     = 4;
    localparam int BLINK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] er = 8'h00;
    logic       ack = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic       hex1dp, err_pending, overflow;
    logic [2:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_q [$];
    logic [7:0] m_code;
    logic       m_ack;
    logic       m_ovf;
    int         m_tick;

    err_code_display #(
        .CODE_W(8), .DEPTH(DEPTH), .BLINK_DIV(BLINK_DIV), .SEG_ACT_LO(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ER_CDE(er), .ack(ack), .clear(clear),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX1DP(hex1dp),
        .err_pending(err_pending), .err_count(err_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b0111111;  4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;  4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;  4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;  4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;  4'h9: glyph = 7'b1101111;
            4'hA: glyph = 7'b1110111;  4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;  4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;  default: glyph = 7'b1110001;
        endcase
    endfunction

    function automatic logic [28:0] model_disp();
        logic phase_on;
        phase_on = ((m_tick / BLINK_DIV) % 2) == 0;
        if (m_q.size() == 0 || (m_ovf && !phase_on))
            return 29'h0;
        return {1'b1, glyph(m_q[0][3:0]), glyph(m_q[0][7:4]), 7'b1010000, 7'b1111001};
    endfunction

    task automatic model_edge();
        logic do_push, do_pop;
        do_push = (er != 8'h00) && (er != m_code);
        do_pop  = ack && !m_ack && (m_q.size() > 0);
        if (clear) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(er);
                else m_ovf = 1'b1;
            end
        end
        m_code = er;
        m_ack  = ack;
        m_tick++;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_code = 8'h00;
        m_ack  = 1'b0;
        m_ovf  = 1'b0;
        m_tick = 0;
    endtask

    task automatic check_state(input logic [28:0] exp_disp);
        chk("disp", {3'b0, hex1dp, hex3, hex2, hex1, hex0}, {3'b0, exp_disp});
        chk("count", 32'(err_count), 32'(m_q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("pending", 32'(err_pending), 32'(m_q.size() != 0));
    endtask

    task automatic step();
        logic [28:0] exp_disp;
        exp_disp = model_disp();
        model_edge();
        @(posedge clk);
        #1;
        check_state(exp_disp);
    endtask

    task automatic hold_reset();
        er = 8'h00; ack = 1'b0; clear = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state(29'h0);
        rst_n = 1'b1;
    endtask

    task automatic push_code(input logic [7:0] c);
        er = c;    step();
        er = 8'h00; step();
    endtask

    initial begin
        model_reset();
        hold_reset();
        repeat (3) step();

        er = 8'h03;
        repeat (10) step();
        er = 8'h00;
        step();
        chk("held_once", 32'(err_count), 32'd1);
        chk("hex3_is_3", 32'(hex3), 32'b1001111);

        clear = 1'b1; step(); clear = 1'b0;
        for (int k = 1; k <= 5; k++) push_code(8'(k));
        chk("ovf_set", 32'(overflow), 32'd1);
        repeat (16) step();

        ack = 1'b1; repeat (3) step();
        ack = 1'b0; step();
        ack = 1'b1; repeat (3) step();
        ack = 1'b0; step();
        chk("after_2_acks", 32'(err_count), 32'd2);

        push_code(8'h07);
        push_code(8'h08);
        er = 8'h06; ack = 1'b1; step();
        er = 8'h00; ack = 1'b0; step();
        chk("full_swap", 32'(err_count), 32'd4);

        clear = 1'b1; step(); clear = 1'b0;
        push_code(8'h1A); push_code(8'hB2); push_code(8'hC3);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_state(29'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("post_reset_count", 32'(err_count), 32'd0);

        push_code(8'h21); push_code(8'h22);
        er = 8'h07; clear = 1'b1; step();
        er = 8'h00; clear = 1'b0; step();

        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r >= 3 && r < 6) er = 8'h00;
            else if (r >= 6) er = (r == 9) ? 8'($urandom) : 8'($urandom_range(1, 6));
            ack   = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 60) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
